dpsk_decode: RTL and testbench

DPSK differential-coherent demodulator, the receive side of the DPSK modulator. It consumes the 10-bit offset-binary carrier samples the modulator emits, on loopback or from an ADC. Each symbol's samples are correlated against the previous symbol's samples and the sign is sliced to recover the original PN bit. Output feeds the PN checker / BER counter.

---
 rtl/dpsk_pkg.sv | 17 +
 rtl/dpsk_sym_buf.sv | 51 +++++
 rtl/dpsk_decode.sv | 130 +++++++++++++
 tb/tb_dpsk_decode.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dpsk_pkg.sv
// dpsk_pkg: shared widths, FSM encoding and sizing helper
// for the DPSK differential-coherent demodulator.
package dpsk_pkg;

  localparam int SAMPLE_W = 10;
  localparam int PROD_W   = 20;
  localparam int MIDSCALE = 512;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  function automatic int acc_width(input int sps);
    return PROD_W + $clog2(sps);
  endfunction

endpackage

// File: rtl/dpsk_sym_buf.sv
// dpsk_sym_buf: SPS-deep read-before-write sample delay line
// with sample counter, wrap and sym_sync realignment.
module dpsk_sym_buf
  import dpsk_pkg::*;
#(
  parameter int SPS = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [SAMPLE_W-1:0]        sample_i,
  input  logic                       valid_i,
  input  logic                       sync_i,
  output logic signed [SAMPLE_W-1:0] s_o,
  output logic signed [SAMPLE_W-1:0] p_o,
  output logic                       last_sample_o
);

  localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(SPS - 1);

  logic [CW-1:0] cnt_q, cnt_d, idx;
  logic signed [SAMPLE_W-1:0] mem_q [SPS];

  // sym_sync pins the current sample to slot 0
  assign idx = sync_i ? '0 : cnt_q;
  assign s_o = {~sample_i[SAMPLE_W-1], sample_i[SAMPLE_W-2:0]};
  assign p_o = mem_q[idx];
  assign last_sample_o = valid_i && (idx == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (valid_i) begin
      cnt_d = (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && valid_i) begin
      mem_q[idx] <= s_o;
    end
  end

endmodule

// File: rtl/dpsk_decode.sv
// dpsk_decode: DPSK demodulator, symbol-delay correlate + slice.
// Define DPSK_ERASE_EN to generate the |acc| < THRESH erasure flag.
module dpsk_decode
  import dpsk_pkg::*;
#(
  parameter int SPS    = 32,
  parameter int ACC_W  = 28,
  parameter int THRESH = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                sample_valid_i,
  input  logic                sym_sync_i,
  output logic                bit_out_o,
  output logic                bit_valid_o,
  output logic                locked_o,
  output logic                bit_erasure_o
);

  if (ACC_W < acc_width(SPS) || SPS < 2 || SPS > 256 || THRESH < 0)
  begin : g_bad_cfg
    $error("dpsk_decode: illegal SPS/ACC_W/THRESH");
  end

  logic [1:0] state_q, state_d;
  logic signed [SAMPLE_W-1:0] s, p;
  logic last;
  logic run, abort;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic pv_q, pv_d, pl_q, pl_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_fin;
  logic bit_q, bit_d, bv_q, bv_d;

  dpsk_sym_buf #(.SPS(SPS)) u_buf (
    .clk           (clk),
    .reset_n       (reset_n),
    .sample_i      (sample_i),
    .valid_i       (sample_valid_i),
    .sync_i        (sym_sync_i),
    .s_o           (s),
    .p_o           (p),
    .last_sample_o (last)
  );

  assign run   = (state_q == ST_RUN);
  assign abort = run && sample_valid_i && sym_sync_i;
  assign acc_fin = acc_q
    + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (sample_valid_i) state_d = ST_PRIME;
      ST_PRIME: if (last) state_d = ST_RUN;
      ST_RUN:   if (abort) state_d = ST_PRIME;
      default:  state_d = ST_IDLE;
    endcase
  end

  // a completed symbol still in flight is sliced even if aborted
  always_comb begin
    prod_d = PROD_W'(s) * PROD_W'(p);
    pv_d   = run && sample_valid_i && !sym_sync_i;
    pl_d   = last;
    acc_d  = acc_q;
    bit_d  = bit_q;
    bv_d   = 1'b0;
    if (pv_q) begin
      if (pl_q) begin
        acc_d = '0;
        bit_d = acc_fin[ACC_W-1];
        bv_d  = 1'b1;
      end else begin
        acc_d = acc_fin;
      end
    end
    if (abort) acc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      prod_q  <= '0;
      pv_q    <= 1'b0;
      pl_q    <= 1'b0;
      acc_q   <= '0;
      bit_q   <= 1'b0;
      bv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      pv_q    <= pv_d;
      pl_q    <= pl_d;
      acc_q   <= acc_d;
      bit_q   <= bit_d;
      bv_q    <= bv_d;
    end
  end

  assign bit_out_o   = bit_q;
  assign bit_valid_o = bv_q;
  assign locked_o    = run;

`ifdef DPSK_ERASE_EN
  localparam logic [ACC_W-1:0] TH_V = ACC_W'(THRESH);
  logic [ACC_W-1:0] mag;
  logic er_q, er_d;

  assign mag = acc_fin[ACC_W-1] ? -acc_fin : acc_fin;

  always_comb begin
    er_d = er_q;
    if (pv_q && pl_q) er_d = (mag < TH_V);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      er_q <= 1'b0;
    end else begin
      er_q <= er_d;
    end
  end

  assign bit_erasure_o = er_q;
`else
  assign bit_erasure_o = 1'b0;
`endif

endmodule

// File: tb/tb_dpsk_decode.sv
// tb_dpsk_decode: randomized DPSK loopback stimulus checked against
// a symbol-level correlation model kept in the bench.
module tb_dpsk_decode;
  import dpsk_pkg::*;

  localparam int SPS = 32;
  localparam int ACC_W = 28;
  localparam int TH = 1000;
  localparam int MID = 512;
  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [9:0] sample;
  logic       valid, sync;
  logic       bo, bv, lk, er;

  dpsk_decode #(.SPS(SPS), .ACC_W(ACC_W), .THRESH(TH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sample_i       (sample),
    .sample_valid_i (valid),
    .sym_sync_i     (sync),
    .bit_out_o      (bo),
    .bit_valid_o    (bv),
    .locked_o       (lk),
    .bit_erasure_o  (er)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // symbol-level model: mode 0 idle, 1 prime, 2 run
  int m_mode, m_idx;
  int prev [SPS];
  int cur [SPS];
  int ev_cyc [$];
  longint ev_sum [$];

  int stream [$];
  int saved [$];
  int ph = 0;
  logic dq [$];
  logic eq [$];
  logic q1 [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_er(input longint sm);
`ifdef DPSK_ERASE_EN
    return ((sm < 0 ? -sm : sm) < TH);
`else
    return (sm != sm);
`endif
  endfunction

  task automatic model_sample(input logic sy, input int raw);
    int s;
    longint acc;
    s = raw - MID;
    if (sy) m_idx = 0;
    if (m_mode == 0) m_mode = 1;
    else if (m_mode == 2 && sy) m_mode = 1;
    cur[m_idx] = s;
    if (m_idx == SPS - 1) begin
      if (m_mode == 2) begin
        acc = 0;
        for (int i = 0; i < SPS; i++)
          acc += longint'(cur[i]) * longint'(prev[i]);
        ev_cyc.push_back(cyc + 1);
        ev_sum.push_back(acc);
      end else begin
        m_mode = 2;
      end
      prev = cur;
    end
    m_idx = (m_idx + 1) % SPS;
  endtask

  task automatic check_outputs(input logic in_rst);
    logic ev;
    longint sm;
    ev = (ev_cyc.size() != 0) && (ev_cyc[0] == cyc);
    chk("bit_valid", bv, ev);
    chk("locked", lk, m_mode == 2);
    if (in_rst) begin
      chk("rst_bit_out", bo, 1'b0);
      chk("rst_erasure", er, 1'b0);
    end
    if (ev) begin
      sm = ev_sum.pop_front();
      void'(ev_cyc.pop_front());
      chk("bit_out", bo, sm < 0);
      chk("bit_erasure", er, exp_er(sm));
    end
    if (bv) begin
      dq.push_back(bo);
      eq.push_back(er);
    end
  endtask

  task automatic step(input logic rn, input logic v, input logic sy,
                      input int s);
    reset_n = rn;
    valid = v;
    sync = sy;
    sample = 10'(s);
    @(posedge clk);
    cyc++;
    if (!rn) begin
      m_mode = 0;
      m_idx = 0;
      ev_cyc.delete();
      ev_sum.delete();
    end else if (v) begin
      model_sample(sy, s);
    end
    #1;
    check_outputs(!rn);
    reset_n = 1'b1;
    valid = 1'b0;
    sync = 1'b0;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, MID);
    step(1'b0, 1'b0, 1'b0, MID);
    dq.delete();
    eq.delete();
  endtask

  task automatic add_sym(input int flip, input int amp);
    real a;
    int n;
    ph ^= flip;
    for (int i = 0; i < SPS; i++) begin
      a = 2.0 * PI * (real'(i) + 0.25) / real'(SPS);
      if (ph != 0) a = a + PI;
      n = (amp > 0) ? int'($urandom_range(12)) - 6 : 0;
      stream.push_back(MID + int'(real'(amp) * $cos(a)) + n);
    end
  endtask

  // ev_kind 1: reset in place of sample ev_pos; 2: sym_sync on it
  task automatic send_stream(input int gapmax, input int ev_pos,
                             input int ev_kind);
    for (int k = 0; k < stream.size(); k++) begin
      if (k == ev_pos && ev_kind == 1) begin
        step(1'b0, 1'b0, 1'b0, MID);
        break;
      end
      step(1'b1, 1'b1, (k == 0) || (k == ev_pos && ev_kind == 2),
           stream[k]);
      repeat ($urandom_range(gapmax)) step(1'b1, 1'b0, 1'b0, MID);
    end
    repeat (4) step(1'b1, 1'b0, 1'b0, MID);
    stream.delete();
  endtask

  int exp1 [5] = '{1, 0, 1, 1, 0};

  initial begin
    reset_n = 1'b0;
    valid = 1'b0;
    sync = 1'b0;
    sample = 10'(MID);
    m_mode = 0;
    m_idx = 0;
    do_reset();

    // loopback: one prime symbol then PN bits 1,0,1,1,0
    add_sym(0, 400);
    foreach (exp1[i]) add_sym(exp1[i], 400);
    send_stream(0, -1, 0);
    chk("t1_count", dq.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < dq.size()) chk("t1_bit", dq[i], exp1[i] != 0);

    // constant phase, four symbols
    do_reset();
    repeat (4) add_sym(0, 450);
    send_stream(0, -1, 0);
    chk("t2_count", dq.size(), 3);
    foreach (dq[i]) chk("t2_bit", dq[i], 1'b0);

    // same stream continuous then with random gaps
    do_reset();
    repeat (9) add_sym(int'($urandom_range(1)), 420);
    saved = stream;
    send_stream(0, -1, 0);
    q1 = dq;
    chk("t3_count", q1.size(), 8);
    do_reset();
    stream = saved;
    send_stream(5, -1, 0);
    chk("t3_gap_count", dq.size(), q1.size());
    foreach (q1[i])
      if (i < dq.size()) chk("t3_gap_bit", dq[i], q1[i]);

    // reset at sample 17 of symbol 3, then fresh prime
    do_reset();
    repeat (6) add_sym(int'($urandom_range(1)), 400);
    send_stream(0, 3 * SPS + 17, 1);
    repeat (3) add_sym(int'($urandom_range(1)), 400);
    send_stream(0, -1, 0);
    chk("t4_count", dq.size(), 4);

    // sym_sync at sample 10 of a RUN symbol
    do_reset();
    repeat (7) add_sym(int'($urandom_range(1)), 400);
    send_stream(0, 3 * SPS + 10, 2);
    chk("t5_count", dq.size(), 4);

    // midscale symbol between full-scale symbols
    do_reset();
    add_sym(0, 480);
    add_sym(0, 0);
    add_sym(0, 480);
    add_sym(0, 480);
    send_stream(0, -1, 0);
    chk("t6_count", dq.size(), 3);
    if (eq.size() == 3) begin
`ifdef DPSK_ERASE_EN
      chk("t6_mid_erasure", eq[0], 1'b1);
      chk("t6_full_erasure", eq[2], 1'b0);
`else
      chk("t6_mid_erasure", eq[0], 1'b0);
      chk("t6_full_erasure", eq[2], 1'b0);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
